verinject_divergence_tracker: RTL and testbench

Synthesizable outcome classifier that sits directly downstream of the golden/injected design pair and the injection monitor. After each injection event it watches the golden and faulty output vectors for a fixed window of valid samples. At the end of the window it reports a classification: masked, recovered or persistent, together with the first divergence cycle, the first XOR syndrome and a mismatch count. It also keeps saturating campaign totals, so long injection runs need no per-cycle `$display` logging.

---
 rtl/verinject_divergence_tracker_if.sv | 36 +++
 rtl/verinject_divergence_tracker.sv | 124 ++++++++++++
 tb/tb_verinject_divergence_tracker.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/verinject_divergence_tracker_if.sv
// Sample/result bus between the golden/injected pair plus monitor and the
// divergence tracker.
interface verinject_divergence_tracker_if #(
  parameter int unsigned WIDTH      = 40,
  parameter int unsigned CYCLE_BITS = 48
);
  logic                  inject_pulse;
  logic [CYCLE_BITS-1:0] cycle_number;
  logic                  sample_valid;
  logic [WIDTH-1:0]      golden;
  logic [WIDTH-1:0]      faulty;
  logic                  busy;
  logic                  result_valid;
  logic [1:0]            result_class;
  logic [CYCLE_BITS-1:0] first_cycle;
  logic [WIDTH-1:0]      first_xor;
  logic [15:0]           mismatch_count;
  logic [15:0]           masked_total;
  logic [15:0]           recovered_total;
  logic [15:0]           persistent_total;
  logic [7:0]            dropped_total;

  modport master (
    output inject_pulse, cycle_number, sample_valid, golden, faulty,
    input  busy, result_valid, result_class, first_cycle, first_xor,
           mismatch_count, masked_total, recovered_total, persistent_total,
           dropped_total
  );

  modport slave (
    input  inject_pulse, cycle_number, sample_valid, golden, faulty,
    output busy, result_valid, result_class, first_cycle, first_xor,
           mismatch_count, masked_total, recovered_total, persistent_total,
           dropped_total
  );
endinterface

// File: rtl/verinject_divergence_tracker.sv
// Classifies each injection as masked/recovered/persistent over a window of
// valid golden/faulty samples and keeps saturating campaign totals.
module verinject_divergence_tracker #(
  parameter int unsigned WIDTH      = 40,
  parameter int unsigned CYCLE_BITS = 48,
  parameter int unsigned WINDOW     = 64
) (
  input logic                          clock,
  input logic                          reset,
  verinject_divergence_tracker_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OBSERVE = 2'd1,
    REPORT  = 2'd2
  } state_t;

  state_t                state, state_next;
  logic [15:0]           window_cnt;
  logic [15:0]           mismatch_count;
  logic [CYCLE_BITS-1:0] first_cycle;
  logic [WIDTH-1:0]      first_xor;
  logic [1:0]            result_class;
  logic [15:0]           masked_total, recovered_total, persistent_total;
  logic [7:0]            dropped_total;

  logic       accept, sample, last_sample, mismatch;
  logic [15:0] count_inc;
  logic [1:0] class_next;

  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    sample      = 1'b0;
    last_sample = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.inject_pulse) begin
          accept     = 1'b1;
          state_next = OBSERVE;
        end
      end
      OBSERVE: begin
        if (bus.sample_valid) begin
          sample = 1'b1;
          if (window_cnt == 16'd1) begin
            last_sample = 1'b1;
            state_next  = REPORT;
          end
        end
      end
      REPORT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign mismatch  = (bus.golden != bus.faulty);
  assign count_inc = (mismatch_count == 16'hFFFF) ? mismatch_count : mismatch_count + 16'd1;

  // Class is resolved on the final sample so it is valid throughout REPORT;
  // the final sample itself decides the last-sample-mismatch outcome.
  always_comb begin
    class_next = 2'd1;
    if (mismatch)                   class_next = 2'd2;
    else if (mismatch_count == '0)  class_next = 2'd0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      window_cnt       <= '0;
      mismatch_count   <= '0;
      first_cycle      <= '0;
      first_xor        <= '0;
      result_class     <= '0;
      masked_total     <= '0;
      recovered_total  <= '0;
      persistent_total <= '0;
      dropped_total    <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        window_cnt     <= 16'(WINDOW);
        mismatch_count <= '0;
        first_cycle    <= '0;
        first_xor      <= '0;
      end
      if (sample) begin
        window_cnt <= window_cnt - 16'd1;
        // A zero count doubles as the first-seen flag: it saturates, never wraps.
        if (mismatch) begin
          mismatch_count <= count_inc;
          if (mismatch_count == '0) begin
            first_cycle <= bus.cycle_number;
            first_xor   <= bus.golden ^ bus.faulty;
          end
        end
      end
      if (last_sample) begin
        result_class <= class_next;
        unique case (class_next)
          2'd0:    if (masked_total != 16'hFFFF)     masked_total     <= masked_total + 16'd1;
          2'd1:    if (recovered_total != 16'hFFFF)  recovered_total  <= recovered_total + 16'd1;
          default: if (persistent_total != 16'hFFFF) persistent_total <= persistent_total + 16'd1;
        endcase
      end
      if (bus.inject_pulse && (state != IDLE) && (dropped_total != 8'hFF))
        dropped_total <= dropped_total + 8'd1;
    end
  end

  assign bus.busy             = (state != IDLE);
  assign bus.result_valid     = (state == REPORT);
  assign bus.result_class     = result_class;
  assign bus.first_cycle      = first_cycle;
  assign bus.first_xor        = first_xor;
  assign bus.mismatch_count   = mismatch_count;
  assign bus.masked_total     = masked_total;
  assign bus.recovered_total  = recovered_total;
  assign bus.persistent_total = persistent_total;
  assign bus.dropped_total    = dropped_total;

endmodule

// File: tb/tb_verinject_divergence_tracker.sv
// Directed bench for verinject_divergence_tracker with a result scoreboard.
module tb_verinject_divergence_tracker;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  verinject_divergence_tracker_if #(.WIDTH(40), .CYCLE_BITS(48)) bus ();

  verinject_divergence_tracker #(.WIDTH(40), .CYCLE_BITS(48), .WINDOW(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          at;
    logic [1:0]  cls;
    logic [47:0] fc;
    logic [39:0] fx;
    logic [15:0] cnt;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad   = 0;
  int cyc;
  int ecnt = 0;
  int n, m;
  int exp_m = 0, exp_r = 0, exp_p = 0, exp_d = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    bus.cycle_number = 48'(cyc);
  endtask

  task automatic drive(input logic inj, input logic val, input logic [39:0] xv);
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    bus.inject_pulse = inj;
    bus.sample_valid = val;
    bus.golden       = r[39:0];
    bus.faulty       = r[39:0] ^ xv;
    tick();
  endtask

  task automatic check_totals(input string tag);
    check({tag, "_masked"},     64'(bus.masked_total),     64'(exp_m));
    check({tag, "_recovered"},  64'(bus.recovered_total),  64'(exp_r));
    check({tag, "_persistent"}, 64'(bus.persistent_total), 64'(exp_p));
    check({tag, "_dropped"},    64'(bus.dropped_total),    64'(exp_d));
  endtask

  // Result monitor: every result_valid strobe must match the next scoreboard entry.
  always @(posedge clock) begin
    exp_t e;
    ecnt++;
    #1;
    if (bus.result_valid) begin
      if (sbq.size() == 0) begin
        check("unexpected_result", 64'd1, 64'd0);
      end else begin
        e = sbq.pop_front();
        check("res_edge",  64'(ecnt),               64'(e.at));
        check("res_class", 64'(bus.result_class),   64'(e.cls));
        check("res_fc",    64'(bus.first_cycle),    64'(e.fc));
        check("res_fx",    64'(bus.first_xor),      64'(e.fx));
        check("res_cnt",   64'(bus.mismatch_count), 64'(e.cnt));
      end
    end
  end

  initial begin
    reset = 1'b1;
    cyc = 1;
    bus.cycle_number = 48'd1;
    bus.inject_pulse = 1'b0;
    bus.sample_valid = 1'b0;
    bus.golden = '0;
    bus.faulty = '0;
    tick();
    tick();
    check("rst_busy",  64'(bus.busy),           64'd0);
    check("rst_valid", 64'(bus.result_valid),   64'd0);
    check("rst_class", 64'(bus.result_class),   64'd0);
    check("rst_cnt",   64'(bus.mismatch_count), 64'd0);
    check_totals("rst");
    reset = 1'b0;
    while (cyc < 10) drive(1'b0, 1'b1, '0);

    // Masked: inject at edge 10, identical outputs throughout
    n = cyc;
    sbq.push_back('{n + 4, 2'd0, 48'd0, 40'd0, 16'd0});
    drive(1'b1, 1'b1, '0);
    check("masked_busy_on", 64'(bus.busy), 64'd1);
    repeat (4) drive(1'b0, 1'b1, '0);
    exp_m++;
    check_totals("masked");
    drive(1'b0, 1'b1, '0);
    check("masked_busy_off", 64'(bus.busy), 64'd0);

    // Recovered: mismatch only on the second window sample; inject-edge sample ignored
    n = cyc;
    sbq.push_back('{n + 4, 2'd1, 48'(n + 2), 40'h0000000100, 16'd1});
    drive(1'b1, 1'b1, 40'hFF);
    drive(1'b0, 1'b1, '0);
    drive(1'b0, 1'b1, 40'h0000000100);
    drive(1'b0, 1'b1, '0);
    drive(1'b0, 1'b1, '0);
    exp_r++;
    check_totals("recovered");
    drive(1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, 40'h3);
    check("hold_class", 64'(bus.result_class), 64'd1);
    check("hold_fx",    64'(bus.first_xor),    64'h100);

    // Persistent: mismatches on the last three samples
    n = cyc;
    sbq.push_back('{n + 4, 2'd2, 48'(n + 2), 40'hA500000001, 16'd3});
    drive(1'b1, 1'b1, '0);
    drive(1'b0, 1'b1, '0);
    drive(1'b0, 1'b1, 40'hA500000001);
    drive(1'b0, 1'b1, 40'h3);
    drive(1'b0, 1'b1, 40'h8000000000);
    exp_p++;
    check_totals("persistent");
    drive(1'b0, 1'b1, '0);

    // Gated samples: two invalid cycles with differing outputs are not compared
    n = cyc;
    sbq.push_back('{n + 6, 2'd1, 48'(n + 3), 40'h1, 16'd1});
    drive(1'b1, 1'b1, '0);
    drive(1'b0, 1'b0, 40'hF0);
    drive(1'b0, 1'b0, 40'hF0);
    drive(1'b0, 1'b1, 40'h1);
    repeat (3) drive(1'b0, 1'b1, '0);
    exp_r++;
    check_totals("gated");
    drive(1'b0, 1'b1, '0);

    // Overlap: injections during OBSERVE and REPORT are dropped
    n = cyc;
    sbq.push_back('{n + 4, 2'd0, 48'd0, 40'd0, 16'd0});
    drive(1'b1, 1'b1, '0);
    drive(1'b0, 1'b1, '0);
    drive(1'b1, 1'b1, '0);
    drive(1'b0, 1'b1, '0);
    drive(1'b0, 1'b1, '0);
    exp_m++;
    drive(1'b1, 1'b1, '0);
    exp_d = 2;
    check_totals("overlap");
    m = cyc;
    sbq.push_back('{m + 4, 2'd2, 48'(m + 4), 40'h7, 16'd1});
    drive(1'b1, 1'b1, '0);
    check("overlap_accept_busy", 64'(bus.busy), 64'd1);
    repeat (3) drive(1'b0, 1'b1, '0);
    drive(1'b1, 1'b1, 40'h7);
    exp_d = 3;
    exp_p++;
    check_totals("final_drop");
    drive(1'b0, 1'b1, '0);

    // Reset mid-window: no report, everything cleared
    drive(1'b1, 1'b1, '0);
    drive(1'b0, 1'b1, 40'h55);
    reset = 1'b1;
    drive(1'b0, 1'b1, 40'h55);
    exp_m = 0; exp_r = 0; exp_p = 0; exp_d = 0;
    check("midrst_busy",  64'(bus.busy),           64'd0);
    check("midrst_valid", 64'(bus.result_valid),   64'd0);
    check("midrst_class", 64'(bus.result_class),   64'd0);
    check("midrst_cnt",   64'(bus.mismatch_count), 64'd0);
    check("midrst_fc",    64'(bus.first_cycle),    64'd0);
    check("midrst_fx",    64'(bus.first_xor),      64'd0);
    check_totals("midrst");
    reset = 1'b0;
    drive(1'b0, 1'b1, '0);
    n = cyc;
    sbq.push_back('{n + 4, 2'd1, 48'(n + 1), 40'h9, 16'd1});
    drive(1'b1, 1'b1, '0);
    drive(1'b0, 1'b1, 40'h9);
    repeat (3) drive(1'b0, 1'b1, '0);
    exp_r = 1;
    check_totals("post_rst");
    drive(1'b0, 1'b1, '0);
    repeat (3) drive(1'b0, 1'b0, '0);
    check("sb_empty", 64'(sbq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
